// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the execute-stage controller and the
// iterative RV32M multiply/divide unit.
interface muldiv_unit_if;
  logic        i_Valid;
  logic        o_Ready;
  logic [2:0]  i_Op;
  logic [31:0] i_Source1;
  logic [31:0] i_Source2;
  logic        o_Valid;
  logic        i_ResultReady;
  logic [31:0] o_Output;
  logic        o_Busy;
  logic        i_Flush;

  // Unit side.
  modport slave (
    input  i_Valid, i_Op, i_Source1, i_Source2, i_ResultReady, i_Flush,
    output o_Ready, o_Valid, o_Output, o_Busy
  );

  // Controller side.
  modport master (
    output i_Valid, i_Op, i_Source1, i_Source2, i_ResultReady, i_Flush,
    input  o_Ready, o_Valid, o_Output, o_Busy
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: 32-cycle shift-add multiply or
// restoring divide on operand magnitudes, one sign-fixup cycle, then the
// result is held until the consumer takes it.
module muldiv_unit (
  input  logic         i_Clock,
  input  logic         i_Reset,
  muldiv_unit_if.slave bus
);

  typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} stateType;

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [2:0] OP_REMU   = 3'd7;

  stateType    state;
  stateType    nextState;

  // Captured operation and datapath registers.
  logic [2:0]  opReg;
  logic        negQuot;      // also the product negate flag
  logic        negRem;
  logic [31:0] operand;      // multiplicand or divisor magnitude
  logic [31:0] multiplier;
  logic [63:0] acc;          // product, or {remainder, quotient}
  logic [4:0]  count;
  logic [31:0] outReg;

  // Accept-time decode of the incoming request.
  logic        reqIsDiv;
  logic        src1Signed;
  logic        src2Signed;
  logic        neg1;
  logic        neg2;
  logic [31:0] abs1;
  logic [31:0] abs2;
  logic        divByZero;
  logic        divOverflow;
  logic        reqSpecial;
  logic [31:0] specialValue;
  logic        accept;

  // One CALC iteration of each algorithm, and the fixup result.
  logic [32:0] mulSum;
  logic [63:0] mulNext;
  logic [33:0] divDiff;
  logic [63:0] divNext;
  logic [63:0] product;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic [31:0] fixResult;

  assign accept = (state == IDLE) && bus.i_Valid && !bus.i_Flush;

  // Decode operand signedness, magnitudes and the short-circuit cases.
  always_comb begin
    reqIsDiv    = bus.i_Op[2];
    src1Signed  = (bus.i_Op == OP_MULH) || (bus.i_Op == OP_MULHSU) ||
                  (bus.i_Op == OP_DIV)  || (bus.i_Op == OP_REM);
    src2Signed  = (bus.i_Op == OP_MULH) || (bus.i_Op == OP_DIV) ||
                  (bus.i_Op == OP_REM);
    neg1        = src1Signed && bus.i_Source1[31];
    neg2        = src2Signed && bus.i_Source2[31];
    abs1        = neg1 ? -bus.i_Source1 : bus.i_Source1;
    abs2        = neg2 ? -bus.i_Source2 : bus.i_Source2;
    divByZero   = reqIsDiv && (bus.i_Source2 == 32'd0);
    divOverflow = ((bus.i_Op == OP_DIV) || (bus.i_Op == OP_REM)) &&
                  (bus.i_Source1 == 32'h8000_0000) &&
                  (bus.i_Source2 == 32'hFFFF_FFFF);
    reqSpecial  = divByZero || divOverflow;
    // i_Op[1] separates REM/REMU from DIV/DIVU.
    if (divByZero) begin
      specialValue = bus.i_Op[1] ? bus.i_Source1 : 32'hFFFF_FFFF;
    end else begin
      specialValue = bus.i_Op[1] ? 32'd0 : 32'h8000_0000;
    end
  end

  // Single iteration of shift-add multiply and restoring divide.
  always_comb begin
    mulSum  = {1'b0, acc[63:32]} + (multiplier[0] ? {1'b0, operand} : 33'd0);
    mulNext = {mulSum, acc[31:1]};
    // The shifted partial remainder can reach 33 bits when the divisor has
    // its MSB set, so the trial subtraction carries one extra sign bit.
    divDiff = {1'b0, acc[63:31]} - {2'b00, operand};
    if (!divDiff[33]) begin
      divNext = {divDiff[31:0], acc[30:0], 1'b1};
    end else begin
      divNext = {acc[62:0], 1'b0};
    end
  end

  // Sign correction and result-word selection for the FIXUP cycle.
  always_comb begin
    product   = negQuot ? -acc : acc;
    quotient  = negQuot ? -acc[31:0] : acc[31:0];
    remainder = negRem ? -acc[63:32] : acc[63:32];
    unique case (opReg)
      OP_MUL:                        fixResult = product[31:0];
      OP_MULH, OP_MULHSU, OP_MULHU:  fixResult = product[63:32];
      OP_DIV, OP_DIVU:               fixResult = quotient;
      default:                       fixResult = remainder;
    endcase
  end

  // State register; reset beats flush, flush beats everything else.
  always_ff @(posedge i_Clock) begin
    // NOTE: every clocked register uses <= so all of them update together
    // from pre-edge values; blocking = here would create order-dependent races.
    if (i_Reset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state logic.
  always_comb begin
    // NOTE: nextState is assigned before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    nextState = state;
    unique case (state)
      IDLE:    if (bus.i_Valid) nextState = reqSpecial ? DONE : CALC;
      CALC:    if (count == 5'd31) nextState = FIXUP;
      FIXUP:   nextState = DONE;
      DONE:    if (bus.i_ResultReady) nextState = IDLE;
      default: nextState = IDLE;
    endcase
    if (bus.i_Flush) begin
      nextState = IDLE;
    end
  end

  // Iteration counter and output register, both with defined reset values.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      count  <= '0;
      outReg <= '0;
    end else if (!bus.i_Flush) begin
      if (accept) begin
        count <= '0;
        if (reqSpecial) begin
          outReg <= specialValue;
        end
      end else if (state == CALC) begin
        count <= count + 5'd1;
      end else if (state == FIXUP) begin
        outReg <= fixResult;
      end
    end
  end

  // Operand capture and the iterative datapath.
  always_ff @(posedge i_Clock) begin
    // NOTE: these registers are deliberately left out of reset: each one is
    // loaded at acceptance before anything reads it, so a reset would only
    // add fan-out to the reset net.
    if (accept) begin
      opReg      <= bus.i_Op;
      negQuot    <= neg1 ^ neg2;
      negRem     <= neg1;
      operand    <= reqIsDiv ? abs2 : abs1;
      multiplier <= abs2;
      acc        <= reqIsDiv ? {32'd0, abs1} : 64'd0;
    end else if (state == CALC && !bus.i_Flush) begin
      acc        <= opReg[2] ? divNext : mulNext;
      multiplier <= {1'b0, multiplier[31:1]};
    end
  end

  assign bus.o_Ready  = (state == IDLE);
  assign bus.o_Valid  = (state == DONE);
  assign bus.o_Busy   = (state != IDLE);
  assign bus.o_Output = outReg;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit: results, latency, special cases,
// flush, back-pressure and mid-operation reset.
module tb_muldiv_unit;

  localparam logic [2:0] MUL    = 3'd0;
  localparam logic [2:0] MULH   = 3'd1;
  localparam logic [2:0] MULHSU = 3'd2;
  localparam logic [2:0] MULHU  = 3'd3;
  localparam logic [2:0] DIV    = 3'd4;
  localparam logic [2:0] DIVU   = 3'd5;
  localparam logic [2:0] REM    = 3'd6;
  localparam logic [2:0] REMU   = 3'd7;

  // Edges from the accept edge to the first edge after which o_Valid is
  // high: 33 for iterative ops (the 34th cycle counting the accept cycle),
  // 0 for short-circuited divides.
  localparam int NORMAL_LAT  = 33;
  localparam int SPECIAL_LAT = 0;

  logic clock;
  logic reset;
  int   errorCount;
  int   checkCount;

  muldiv_unit_if bus ();

  muldiv_unit dut (
    .i_Clock (clock),
    .i_Reset (reset),
    .bus     (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] actual,
                       input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Issue one request from IDLE, wait (bounded) for the result, check it
  // and its latency. With holdReady set, the result is left unclaimed for
  // five cycles before being taken.
  task automatic runOp(input string tag, input logic [2:0] op,
                       input logic [31:0] src1, input logic [31:0] src2,
                       input logic [31:0] expected, input int expLat,
                       input bit holdReady);
    int lat;
    bus.i_Valid       = 1'b1;
    bus.i_Op          = op;
    bus.i_Source1     = src1;
    bus.i_Source2     = src2;
    bus.i_ResultReady = !holdReady;
    tick();
    bus.i_Valid   = 1'b0;
    bus.i_Op      = 3'($urandom());
    bus.i_Source1 = $urandom();
    bus.i_Source2 = $urandom();
    lat = 0;
    while (!bus.o_Valid && lat < 40) begin
      tick();
      lat++;
    end
    check({tag, " latency"}, 32'(lat), 32'(expLat));
    check({tag, " result"}, bus.o_Output, expected);
    if (holdReady) begin
      for (int i = 0; i < 5; i++) begin
        tick();
        check({tag, " held result"}, bus.o_Output, expected);
        check({tag, " held ready"}, 32'(bus.o_Ready), 32'd0);
      end
      bus.i_ResultReady = 1'b1;
    end
    tick();
    check({tag, " ready after take"}, 32'(bus.o_Ready), 32'd1);
  endtask

  initial begin
    bit sawValid;
    errorCount        = 0;
    checkCount        = 0;
    reset             = 1'b1;
    bus.i_Valid       = 1'b0;
    bus.i_Op          = MUL;
    bus.i_Source1     = '0;
    bus.i_Source2     = '0;
    bus.i_ResultReady = 1'b1;
    bus.i_Flush       = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    check("reset ready",  32'(bus.o_Ready), 32'd1);
    check("reset valid",  32'(bus.o_Valid), 32'd0);
    check("reset busy",   32'(bus.o_Busy),  32'd0);
    check("reset output", bus.o_Output,     32'd0);

    runOp("MUL 7*-3",        MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, NORMAL_LAT, 1'b0);
    runOp("MULHU max*max",   MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, NORMAL_LAT, 1'b0);
    runOp("MULHSU -1*max",   MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, NORMAL_LAT, 1'b0);
    runOp("DIV -7/2",        DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, NORMAL_LAT, 1'b0);
    runOp("REM -7/2",        REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, NORMAL_LAT, 1'b0);
    runOp("REMU 5/3",        REMU,   32'd5,         32'd3,         32'd2,         NORMAL_LAT, 1'b0);
    runOp("DIVU big divisor", DIVU,  32'hFFFF_FFFE, 32'h8000_0001, 32'd1,         NORMAL_LAT, 1'b0);
    runOp("DIVU 5/0",        DIVU,   32'd5,         32'd0,         32'hFFFF_FFFF, SPECIAL_LAT, 1'b0);
    runOp("REMU 5/0",        REMU,   32'd5,         32'd0,         32'd5,         SPECIAL_LAT, 1'b0);
    runOp("DIV overflow",    DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, SPECIAL_LAT, 1'b0);
    runOp("REM overflow",    REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         SPECIAL_LAT, 1'b0);
    runOp("MULH min*min",    MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, NORMAL_LAT, 1'b1);

    // Flush during the 10th CALC cycle: the unit returns to IDLE, never
    // raises o_Valid, and the previous result stays on o_Output.
    bus.i_Valid   = 1'b1;
    bus.i_Op      = MUL;
    bus.i_Source1 = 32'd9;
    bus.i_Source2 = 32'd9;
    tick();
    bus.i_Valid = 1'b0;
    sawValid    = 1'b0;
    for (int i = 0; i < 9; i++) begin
      tick();
      if (bus.o_Valid) sawValid = 1'b1;
    end
    bus.i_Flush = 1'b1;
    tick();
    bus.i_Flush = 1'b0;
    check("flush ready",       32'(bus.o_Ready), 32'd1);
    check("flush busy",        32'(bus.o_Busy),  32'd0);
    check("flush keeps output", bus.o_Output,    32'h4000_0000);
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.o_Valid) sawValid = 1'b1;
    end
    check("flush never valid", 32'(sawValid), 32'd0);

    // Flush together with a request: nothing is accepted.
    bus.i_Valid   = 1'b1;
    bus.i_Flush   = 1'b1;
    bus.i_Op      = DIVU;
    bus.i_Source1 = 32'd1;
    bus.i_Source2 = 32'd0;
    tick();
    bus.i_Valid = 1'b0;
    bus.i_Flush = 1'b0;
    check("flush+valid ready",  32'(bus.o_Ready), 32'd1);
    check("flush+valid busy",   32'(bus.o_Busy),  32'd0);
    check("flush+valid output", bus.o_Output,     32'h4000_0000);

    runOp("MUL 3*4 after flush", MUL, 32'd3, 32'd4, 32'd12, NORMAL_LAT, 1'b0);

    // Reset in the middle of CALC.
    bus.i_Valid   = 1'b1;
    bus.i_Op      = DIV;
    bus.i_Source1 = 32'd100;
    bus.i_Source2 = 32'd7;
    tick();
    bus.i_Valid = 1'b0;
    repeat (5) tick();
    check("mid-CALC busy", 32'(bus.o_Busy), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid reset ready",  32'(bus.o_Ready), 32'd1);
    check("mid reset valid",  32'(bus.o_Valid), 32'd0);
    check("mid reset busy",   32'(bus.o_Busy),  32'd0);
    check("mid reset output", bus.o_Output,     32'd0);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
